// File: rtl/cordic_pkg.sv
// ============================================================================
//  Package     : cordic_pkg
//  Description : Shared constants for the CORDIC sweep sequencer: FSM state
//                encoding, Q2.14 / Q1.7 format constants and angle limits.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

   // Sequencer state encoding
   localparam int         STATE_W     = 3;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_ISSUE    = 3'd1;
   localparam logic [2:0] ST_WAIT     = 3'd2;
   localparam logic [2:0] ST_SEND_SIN = 3'd3;
   localparam logic [2:0] ST_SEND_COS = 3'd4;
   localparam logic [2:0] ST_ADVANCE  = 3'd5;

   // Sample formats: CORDIC delivers signed Q2.14, the byte stream carries signed Q1.7
   localparam int Q214_W    = 16;
   localparam int Q214_FRAC = 14;
   localparam int S8_W      = 8;
   localparam int S8_FRAC   = 7;
   localparam int FMT_SHIFT = Q214_FRAC - S8_FRAC;
   localparam int FMT_ROUND = 1 << (FMT_SHIFT - 1);
   // Symmetric range: -128 is deliberately excluded
   localparam int S8_MAX    = 127;
   localparam int S8_MIN    = -127;

   // Angle handling (degrees)
   localparam int ANGLE_W         = 9;
   localparam int FULL_CIRCLE_DEG = 360;
   localparam int MAX_STEP_DEG    = FULL_CIRCLE_DEG - 1;

   // CORDIC timing; default timeout leaves a 30-cycle margin over nominal latency
   localparam int CORDIC_LATENCY  = 33;
   localparam int TIMEOUT_DEFAULT = CORDIC_LATENCY + 30;

endpackage

`default_nettype wire

// File: rtl/q214_to_s8.sv
// ============================================================================
//  Module      : q214_to_s8
//  Description : Combinational conversion of a signed Q2.14 value to a signed
//                Q1.7 byte: round half up ((v + 64) >>> 7 in 17-bit signed
//                arithmetic), then saturate to [-127, +127].
//  Ports       : i_q214 - signed Q2.14 input
//                o_s8   - signed Q1.7 output byte
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q214_to_s8
   import cordic_pkg::*;
(
   input  logic [Q214_W-1:0] i_q214,
   output logic [S8_W-1:0]   o_s8
);

   localparam logic signed [Q214_W:0] c_round = (Q214_W+1)'(FMT_ROUND);
   localparam logic signed [Q214_W:0] c_max   = (Q214_W+1)'(S8_MAX);
   localparam logic signed [Q214_W:0] c_min   = (Q214_W+1)'(S8_MIN);

   logic signed [Q214_W:0] w_ext;
   logic signed [Q214_W:0] w_sum;
   logic signed [Q214_W:0] w_shr;

   // One guard bit keeps the rounding add from overflowing near +2.0
   assign w_ext = {i_q214[Q214_W-1], i_q214};
   assign w_sum = w_ext + c_round;
   assign w_shr = w_sum >>> FMT_SHIFT;

   always_comb begin
      o_s8 = w_shr[S8_W-1:0];
      if (w_shr > c_max) begin
         o_s8 = c_max[S8_W-1:0];
      end else if (w_shr < c_min) begin
         o_s8 = c_min[S8_W-1:0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/cordic_sweep_sequencer.sv
// ============================================================================
//  Module      : cordic_sweep_sequencer
//  Description : Steps a degree angle around the circle, drives a CORDIC
//                sin/cos core, captures both results on a rising done and
//                streams them as Q1.7 bytes (sine then cosine) over a
//                valid/ready interface. A stuck CORDIC is retried after
//                TIMEOUT_CYCLES wait cycles and flagged with a sticky error.
//  Ports       : clk, reset (async, active-high)
//                en, step_deg                     - run control
//                cordic_start/angle/sine/cosine/done - CORDIC handshake
//                out_data/valid/ready/is_cos      - byte stream
//                err_timeout                      - sticky timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_sweep_sequencer
   import cordic_pkg::*;
#(
   parameter int START_ANGLE    = 0,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [8:0]        step_deg,
   output logic              cordic_start,
   output logic [15:0]       cordic_angle,
   input  logic [Q214_W-1:0] cordic_sine,
   input  logic [Q214_W-1:0] cordic_cosine,
   input  logic              cordic_done,
   output logic [S8_W-1:0]   out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_is_cos,
   output logic              err_timeout
);

   localparam int                   TIMER_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TIMER_W-1:0]   c_timer_last = TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ANGLE_W:0]     c_full       = (ANGLE_W+1)'(FULL_CIRCLE_DEG);
   localparam logic [ANGLE_W-1:0]   c_max_step   = ANGLE_W'(MAX_STEP_DEG);
   localparam logic [ANGLE_W-1:0]   c_start_ang  = ANGLE_W'(START_ANGLE);

   logic [STATE_W-1:0] r_state;
   logic [ANGLE_W-1:0] r_angle;
   logic [TIMER_W-1:0] r_timer;
   logic               r_done_q;
   logic [Q214_W-1:0]  r_cos;
   logic               r_start;
   logic [S8_W-1:0]    r_out_data;
   logic               r_out_valid;
   logic               r_out_is_cos;
   logic               r_err_timeout;

   logic [ANGLE_W-1:0] w_step;
   logic [ANGLE_W:0]   w_sum;
   logic [ANGLE_W-1:0] w_angle_next;
   logic [Q214_W-1:0]  w_fmt_in;
   logic [S8_W-1:0]    w_fmt_out;
   logic               w_done_rise;

   // Angle accumulator: clamp the step, then wrap once (sum is at most 718)
   assign w_step       = (step_deg > c_max_step) ? c_max_step : step_deg;
   assign w_sum        = {1'b0, r_angle} + {1'b0, w_step};
   assign w_angle_next = (w_sum >= c_full) ? ANGLE_W'(w_sum - c_full) : ANGLE_W'(w_sum);

   assign w_done_rise  = cordic_done & ~r_done_q;

   // Single converter: live sine while capturing in WAIT, captured cosine afterwards
   assign w_fmt_in = (r_state == ST_WAIT) ? cordic_sine : r_cos;

   q214_to_s8 u_fmt (
      .i_q214 (w_fmt_in),
      .o_s8   (w_fmt_out)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_angle       <= c_start_ang;
         r_timer       <= '0;
         r_done_q      <= 1'b0;
         r_cos         <= '0;
         r_start       <= 1'b0;
         r_out_data    <= '0;
         r_out_valid   <= 1'b0;
         r_out_is_cos  <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         r_start  <= 1'b0;
         r_done_q <= cordic_done;
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  r_state <= ST_ISSUE;
                  r_start <= 1'b1;
               end
            end
            ST_ISSUE: begin
               r_timer <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // Capture wins over a timeout landing in the same cycle
               if (w_done_rise) begin
                  r_cos        <= cordic_cosine;
                  r_out_data   <= w_fmt_out;
                  r_out_valid  <= 1'b1;
                  r_out_is_cos <= 1'b0;
                  r_state      <= ST_SEND_SIN;
               end else if (r_timer == c_timer_last) begin
                  r_err_timeout <= 1'b1;
                  r_state       <= ST_ISSUE;
                  r_start       <= 1'b1;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_SEND_SIN: begin
               if (out_ready) begin
                  r_out_data   <= w_fmt_out;
                  r_out_is_cos <= 1'b1;
                  r_state      <= ST_SEND_COS;
               end
            end
            ST_SEND_COS: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_ADVANCE;
               end
            end
            ST_ADVANCE: begin
               r_angle <= w_angle_next;
               if (en) begin
                  r_state <= ST_ISSUE;
                  r_start <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cordic_start = r_start;
   assign cordic_angle = {{(16-ANGLE_W){1'b0}}, r_angle};
   assign out_data     = r_out_data;
   assign out_valid    = r_out_valid;
   assign out_is_cos   = r_out_is_cos;
   assign err_timeout  = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_cordic_sweep_sequencer.sv
// ============================================================================
//  Module      : tb_cordic_sweep_sequencer
//  Description : Self-checking bench for cordic_sweep_sequencer with a
//                behavioural CORDIC model (programmable latency, mute and
//                stuck-done controls).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_sweep_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [8:0]  step_deg = 9'd0;
   logic        cordic_start;
   logic [15:0] cordic_angle;
   logic [15:0] cordic_sine;
   logic [15:0] cordic_cosine;
   logic        cordic_done;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_is_cos;
   logic        err_timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural CORDIC model
   logic [15:0] m_sin = 16'h0000;
   logic [15:0] m_cos = 16'h0000;
   logic        m_mute = 1'b0;
   logic        m_stuck = 1'b0;
   logic        m_done = 1'b0;
   logic [5:0]  m_cnt = 6'd0;
   logic [15:0] m_sine_q = 16'h0000;
   logic [15:0] m_cos_q = 16'h0000;
   int          m_lat = 33;

   always @(posedge clk) begin
      if (cordic_start) begin
         m_done <= 1'b0;
         m_cnt  <= 6'(m_lat);
      end else if (m_cnt != 6'd0) begin
         m_cnt <= m_cnt - 6'd1;
         if (m_cnt == 6'd1 && !m_mute) begin
            m_done   <= 1'b1;
            m_sine_q <= m_sin;
            m_cos_q  <= m_cos;
         end
      end
   end

   assign cordic_done   = m_done | m_stuck;
   assign cordic_sine   = m_sine_q;
   assign cordic_cosine = m_cos_q;

   always #5 clk = ~clk;

   cordic_sweep_sequencer #(
      .START_ANGLE    (0),
      .TIMEOUT_CYCLES (63)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .step_deg      (step_deg),
      .cordic_start  (cordic_start),
      .cordic_angle  (cordic_angle),
      .cordic_sine   (cordic_sine),
      .cordic_cosine (cordic_cosine),
      .cordic_done   (cordic_done),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_is_cos    (out_is_cos),
      .err_timeout   (err_timeout)
   );

   typedef struct {
      int          step;    // step applied on the way to this sample
      int          angle;
      logic [15:0] sin_v;
      logic [15:0] cos_v;
      logic [7:0]  exp_s;
      logic [7:0]  exp_c;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_start(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cordic_start) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk({name, "_start_seen"}, 0, 1);
   endtask

   task automatic collect(input string name, input logic [7:0] exp_d, input logic exp_c);
      bit got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk({name, "_valid"}, int'(got), 1);
      chk({name, "_data"}, int'(out_data), int'(exp_d));
      chk({name, "_is_cos"}, int'(out_is_cos), int'(exp_c));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n_starts;
      int gap;
      int err_pre;
      int err_post;
      bit data_moved, valid_dropped, cos_flag, start_seen;
      logic [7:0] held;

      vecs[0]  = '{90,  0,   16'h0000, 16'h4000, 8'h00, 8'h7F};
      vecs[1]  = '{90,  90,  16'h4000, 16'h0000, 8'h7F, 8'h00};
      vecs[2]  = '{90,  180, 16'h0000, 16'hC006, 8'h00, 8'h81};
      vecs[3]  = '{90,  270, 16'hC000, 16'h0000, 8'h81, 8'h00};
      vecs[4]  = '{90,  0,   16'hBFC0, 16'h8000, 8'h81, 8'h81};
      vecs[5]  = '{0,   0,   16'h7FFF, 16'h0040, 8'h7F, 8'h01};
      vecs[6]  = '{400, 359, 16'h00BF, 16'hFFC0, 8'h01, 8'h00};
      vecs[7]  = '{2,   1,   16'h003F, 16'hFF3F, 8'h00, 8'hFE};
      vecs[8]  = '{349, 350, 16'h2000, 16'hE000, 8'h40, 8'hC0};
      vecs[9]  = '{350, 340, 16'h0080, 16'hFF80, 8'h01, 8'hFF};
      vecs[10] = '{360, 339, 16'h4000, 16'hC000, 8'h7F, 8'h81};

      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      chk("rst_start", int'(cordic_start), 0);
      chk("rst_angle", int'(cordic_angle), 0);
      chk("rst_data", int'(out_data), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_is_cos", int'(out_is_cos), 0);
      chk("rst_err", int'(err_timeout), 0);
      reset = 1'b0;

      n_starts = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cordic_start) n_starts++;
      end
      chk("idle_no_start", n_starts, 0);

      // Table-driven sweep
      en = 1'b1;
      for (int i = 0; i < 11; i++) begin
         step_deg = 9'(vecs[i].step);
         m_sin    = vecs[i].sin_v;
         m_cos    = vecs[i].cos_v;
         wait_start($sformatf("v%0d", i));
         chk($sformatf("v%0d_angle", i), int'(cordic_angle), vecs[i].angle);
         collect($sformatf("v%0d_sin", i), vecs[i].exp_s, 1'b0);
         collect($sformatf("v%0d_cos", i), vecs[i].exp_c, 1'b1);
      end

      // Backpressure on the sine byte
      step_deg = 9'd0;
      m_sin = 16'h4000;
      m_cos = 16'h0000;
      out_ready = 1'b0;
      wait_start("bp");
      chk("bp_angle", int'(cordic_angle), 339);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) break;
      end
      chk("bp_valid", int'(out_valid), 1);
      held = out_data;
      data_moved = 1'b0; valid_dropped = 1'b0; cos_flag = 1'b0; start_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_data !== held) data_moved = 1'b1;
         if (out_valid !== 1'b1) valid_dropped = 1'b1;
         if (out_is_cos !== 1'b0) cos_flag = 1'b1;
         if (cordic_start) start_seen = 1'b1;
      end
      chk("bp_data_hold", int'(data_moved), 0);
      chk("bp_valid_hold", int'(valid_dropped), 0);
      chk("bp_is_cos_hold", int'(cos_flag), 0);
      chk("bp_no_start", int'(start_seen), 0);
      chk("bp_sin_data", int'(out_data), 8'h7F);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      collect("bp_cos", 8'h00, 1'b1);

      // CORDIC never answers: timeout and retry with the same angle
      m_mute = 1'b1;
      wait_start("to");
      chk("to_angle", int'(cordic_angle), 339);
      gap = 0; err_pre = -1; err_post = -1;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (n == 63) err_pre = int'(err_timeout);
         if (cordic_start) begin
            gap = n;
            err_post = int'(err_timeout);
            break;
         end
      end
      chk("to_gap", gap, 64);
      chk("to_err_before", err_pre, 0);
      chk("to_err_after", err_post, 1);
      chk("to_retry_angle", int'(cordic_angle), 339);

      // Done stuck high: a stale level must not trigger capture
      m_stuck = 1'b1;
      gap = 0; valid_dropped = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (out_valid) valid_dropped = 1'b1;
         if (cordic_start) begin
            gap = n;
            break;
         end
      end
      chk("stale_gap", gap, 64);
      chk("stale_no_capture", int'(valid_dropped), 0);
      chk("stale_err", int'(err_timeout), 1);

      // Recovery on the retry
      m_stuck = 1'b0;
      m_mute  = 1'b0;
      m_sin   = 16'hC006;
      m_cos   = 16'h4000;
      collect("rec_sin", 8'h81, 1'b0);
      collect("rec_cos", 8'h7F, 1'b1);

      // Reset asserted in WAIT aborts immediately
      m_sin = 16'h2000;
      m_cos = 16'hE000;
      wait_start("rw");
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rw_angle", int'(cordic_angle), 0);
      chk("rw_start", int'(cordic_start), 0);
      chk("rw_valid", int'(out_valid), 0);
      chk("rw_data", int'(out_data), 0);
      chk("rw_err", int'(err_timeout), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_start("rw2");
      chk("rw2_angle", int'(cordic_angle), 0);
      collect("rw2_sin", 8'h40, 1'b0);
      collect("rw2_cos", 8'hC0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
